// File: rtl/cnn_loader_pkg.sv
// Shared types for the CNN_16 boot loader: FSM states, error codes, program terminator.
// The LD_CKSUM state exists only when CNN_LOADER_CKSUM_EN is defined.
package cnn_loader_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LD_KERN,
        LD_IMG,
        LD_PROG,
`ifdef CNN_LOADER_CKSUM_EN
        LD_CKSUM,
`endif
        RELEASE,
        RUN,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_PROG_OVF = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_CKSUM    = 2'd3;

    localparam logic [15:0] PROG_END_WORD = 16'hFFFF;

    function automatic logic is_load_state(input state_t s);
`ifdef CNN_LOADER_CKSUM_EN
        return (s == LD_KERN) || (s == LD_IMG) || (s == LD_PROG) || (s == LD_CKSUM);
`else
        return (s == LD_KERN) || (s == LD_IMG) || (s == LD_PROG);
`endif
    endfunction

endpackage

// File: rtl/cnn_mem_loader_if.sv
// Host word stream plus CPU external-memory write port; slave = loader, master = host/bench side.
interface cnn_mem_loader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              mem_sel;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_data;

    modport master (
        output s_valid, s_data,
        input  s_ready, mem_sel, mem_we, mem_adr, mem_data
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, mem_sel, mem_we, mem_adr, mem_data
    );
endinterface

// File: rtl/cnn_mem_loader.sv
// Boot sequencer: streams kernel, image, program into memory, then releases the CPU and watches its PC.
// Word accepted at edge n is written in cycle n+1; s_ready only in LD_* states. Optional CNN_LOADER_CKSUM_EN.
module cnn_mem_loader
    import cnn_loader_pkg::*;
#(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 12,
    parameter int                K_DIM       = 3,
    parameter int                IMG_W       = 16,
    parameter int                IMG_H       = 16,
    parameter logic [ADDR_W-1:0] KERN_BASE   = 12'h000,
    parameter logic [ADDR_W-1:0] PROG_BASE   = 12'h010,
    parameter logic [ADDR_W-1:0] IMG_BASE    = 12'h100,
    parameter int                PROG_MAX    = 64,
    parameter int                TIMEOUT_CYC = 100000
) (
    input  logic                          clkn,
    input  logic                          rstn,
    input  logic                          start,
    cnn_mem_loader_if.slave               bus,
    input  logic [ADDR_W-1:0]             pc_value,
    output logic                          busy,
    output logic                          done,
    output logic [1:0]                    error,
    output logic [$clog2(PROG_MAX+1)-1:0] prog_len
);

    localparam int KERN_WORDS = K_DIM * K_DIM;
    localparam int IMG_WORDS  = IMG_W * IMG_H;
    localparam int CNT_W      = $clog2(KERN_WORDS + IMG_WORDS + PROG_MAX);
    localparam int TMO_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int PL_W       = $clog2(PROG_MAX + 1);
`ifdef CNN_LOADER_CKSUM_EN
    localparam state_t AFTER_PROG = LD_CKSUM;
`else
    localparam state_t AFTER_PROG = RELEASE;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [ADDR_W-1:0] end_adr_q, end_adr_d;
    logic              s_ready_q, s_ready_d;
    logic              mem_sel_q, mem_sel_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        error_q, error_d;
    logic [PL_W-1:0]   prog_len_q, prog_len_d;
    logic              acc;
`ifdef CNN_LOADER_CKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
`endif

    assign acc          = bus.s_valid && s_ready_q;
    assign bus.s_ready  = s_ready_q;
    assign bus.mem_sel  = mem_sel_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_adr  = mem_adr_q;
    assign bus.mem_data = mem_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign prog_len     = prog_len_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        end_adr_d  = end_adr_q;
        mem_sel_d  = mem_sel_q;
        mem_we_d   = 1'b0;
        mem_adr_d  = mem_adr_q;
        mem_data_d = mem_data_q;
        done_d     = done_q;
        error_d    = error_q;
        prog_len_d = prog_len_q;
`ifdef CNN_LOADER_CKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = LD_KERN;
                    cnt_d      = '0;
                    mem_sel_d  = 1'b1;
                    done_d     = 1'b0;
                    error_d    = ERR_NONE;
                    prog_len_d = '0;
`ifdef CNN_LOADER_CKSUM_EN
                    sum_d      = '0;
`endif
                end
            end
            LD_KERN: if (acc) begin
                mem_we_d   = 1'b1;
                mem_adr_d  = KERN_BASE + ADDR_W'(cnt_q);
                mem_data_d = bus.s_data;
                if (cnt_q == CNT_W'(KERN_WORDS - 1)) begin
                    cnt_d   = '0;
                    state_d = LD_IMG;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LD_IMG: if (acc) begin
                mem_we_d   = 1'b1;
                mem_adr_d  = IMG_BASE + ADDR_W'(cnt_q);
                mem_data_d = bus.s_data;
                if (cnt_q == CNT_W'(IMG_WORDS - 1)) begin
                    cnt_d   = '0;
                    state_d = LD_PROG;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LD_PROG: if (acc) begin
                mem_we_d   = 1'b1;
                mem_adr_d  = PROG_BASE + ADDR_W'(cnt_q);
                mem_data_d = bus.s_data;
                prog_len_d = prog_len_q + 1'b1;
                // The end word wins over overflow when it is the PROG_MAX-th word.
                if (bus.s_data == DATA_W'(PROG_END_WORD)) begin
                    end_adr_d = PROG_BASE + ADDR_W'(cnt_q);
                    state_d   = AFTER_PROG;
                end else if (cnt_q == CNT_W'(PROG_MAX - 1)) begin
                    error_d = ERR_PROG_OVF;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef CNN_LOADER_CKSUM_EN
            LD_CKSUM: if (acc) begin
                if (bus.s_data == sum_q) begin
                    state_d = RELEASE;
                end else begin
                    error_d = ERR_CKSUM;
                    state_d = ERR;
                end
            end
`endif
            RELEASE: begin
                mem_sel_d = 1'b0;
                tmo_d     = '0;
                state_d   = RUN;
            end
            RUN: begin
                if (pc_value == end_adr_q) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    error_d   = ERR_TIMEOUT;
                    mem_sel_d = 1'b1;
                    state_d   = ERR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef CNN_LOADER_CKSUM_EN
        if (acc && (state_q == LD_KERN || state_q == LD_IMG || state_q == LD_PROG)) begin
            sum_d = sum_q + bus.s_data;
        end
`endif
        s_ready_d = is_load_state(state_d);
        busy_d    = !(state_d == IDLE || state_d == DONE || state_d == ERR);
    end

    always_ff @(posedge clkn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tmo_q      <= '0;
            end_adr_q  <= '0;
            s_ready_q  <= 1'b0;
            mem_sel_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_adr_q  <= '0;
            mem_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= ERR_NONE;
            prog_len_q <= '0;
`ifdef CNN_LOADER_CKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            end_adr_q  <= end_adr_d;
            s_ready_q  <= s_ready_d;
            mem_sel_q  <= mem_sel_d;
            mem_we_q   <= mem_we_d;
            mem_adr_q  <= mem_adr_d;
            mem_data_q <= mem_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            prog_len_q <= prog_len_d;
`ifdef CNN_LOADER_CKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_cnn_mem_loader.sv
// Bench for cnn_mem_loader: expected memory writes are queued by the stimulus and popped by a write monitor.
module tb_cnn_mem_loader;

    logic        clkn = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [11:0] pc_value = 12'h000;
    logic        busy, done;
    logic [1:0]  error;
    logic [6:0]  prog_len;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    logic [15:0] sum = 16'h0000;
    logic [27:0] exp_q[$];

    cnn_mem_loader_if #(.DATA_W(16), .ADDR_W(12)) ifc();

    cnn_mem_loader #(.TIMEOUT_CYC(50)) dut (
        .clkn     (clkn),
        .rstn     (rstn),
        .start    (start),
        .bus      (ifc),
        .pc_value (pc_value),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .prog_len (prog_len)
    );

    always #5 clkn = ~clkn;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Write monitor: every mem_we cycle must match the oldest queued expectation.
    always @(negedge clkn) begin
        if (ifc.mem_we === 1'b1) begin
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got adr=%h data=%h, required no write", ifc.mem_adr, ifc.mem_data);
            end else begin
                logic [27:0] e;
                e = exp_q.pop_front();
                if ({ifc.mem_adr, ifc.mem_data} !== e || ifc.mem_sel !== 1'b1) begin
                    errors++;
                    $display("FAIL write: got adr=%h data=%h sel=%b, required adr=%h data=%h sel=1",
                             ifc.mem_adr, ifc.mem_data, ifc.mem_sel, e[27:16], e[15:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkn);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        sum = 16'h0000;
    endtask

    task automatic send_w(input logic [15:0] d, input bit wr, input logic [11:0] adr);
        int n = 0;
        if (wr) begin
            exp_q.push_back({adr, d});
            sum = sum + d;
        end
        ifc.s_valid = 1'b1;
        ifc.s_data  = d;
        @(negedge clkn);
        while (ifc.s_ready !== 1'b1 && n < 50) begin
            n++;
            @(negedge clkn);
        end
        if (ifc.s_ready !== 1'b1) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout: word %h not accepted, s_ready=%b required 1", d, ifc.s_ready);
        end
        tick();
    endtask

    // Kernel then image; optional 1,0,0,1 valid gap (with an ignored start pulse) after image word 40.
    task automatic load_front(input bit gaps, input int n_img);
        for (int i = 0; i < 9; i++) send_w(16'h0A00 + 16'(i), 1'b1, 12'h000 + 12'(i));
        for (int i = 0; i < n_img; i++) begin
            send_w(16'h2000 + 16'(i * 3), 1'b1, 12'h100 + 12'(i));
            if (gaps && i == 40) begin
                ifc.s_valid = 1'b0;
                start = 1'b1;
                tick();
                start = 1'b0;
                tick();
            end
        end
    endtask

    // Program 0300..0308, 3000, FFFF; with checksum enabled the sum word (plus delta) follows.
    task automatic load_prog(input logic [15:0] ck_delta);
        for (int j = 0; j < 9; j++) send_w(16'h0300 + 16'(j), 1'b1, 12'h010 + 12'(j));
        send_w(16'h3000, 1'b1, 12'h019);
        send_w(16'hFFFF, 1'b1, 12'h01A);
`ifdef CNN_LOADER_CKSUM_EN
        send_w(sum + ck_delta, 1'b0, 12'h000);
`else
        if (ck_delta != 16'h0000) chk("ck_delta_unused", 32'(ck_delta), 32'h0);
`endif
        ifc.s_valid = 1'b0;
    endtask

    initial begin
        int k;
        ifc.s_valid = 1'b0;
        ifc.s_data  = 16'h0000;
        repeat (3) tick();
        chk("rst_mem_sel", ifc.mem_sel, 1);
        chk("rst_mem_we", ifc.mem_we, 0);
        chk("rst_mem_adr", ifc.mem_adr, 0);
        chk("rst_mem_data", ifc.mem_data, 0);
        chk("rst_s_ready", ifc.s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_prog_len", prog_len, 0);
        rstn = 1'b1;
        tick();

        // Full load with backpressure, then the CPU reaches the end word.
        wr_cnt = 0;
        pulse_start();
        chk("start_busy", busy, 1);
        chk("start_s_ready", ifc.s_ready, 1);
        load_front(1'b1, 256);
        load_prog(16'h0000);
        tick();
        chk("rel_mem_sel", ifc.mem_sel, 0);
        chk("rel_mem_we", ifc.mem_we, 0);
        chk("rel_s_ready", ifc.s_ready, 0);
        chk("rel_done", done, 0);
        chk("main_prog_len", prog_len, 11);
        chk("main_wr_cnt", wr_cnt, 276);
        chk("main_drain", exp_q.size(), 0);
        pc_value = 12'h01A;
        tick();
        chk("run_done", done, 1);
        chk("run_busy", busy, 0);
        chk("run_error", error, 0);
        tick();
        chk("done_mem_sel", ifc.mem_sel, 0);

        // Program overflow: 64 words, no end word.
        wr_cnt = 0;
        pulse_start();
        chk("restart_done_clr", done, 0);
        chk("restart_mem_sel", ifc.mem_sel, 1);
        chk("restart_prog_len", prog_len, 0);
        load_front(1'b0, 256);
        for (int j = 0; j < 64; j++) send_w(16'h0400 + 16'(j), 1'b1, 12'h010 + 12'(j));
        ifc.s_valid = 1'b0;
        tick();
        chk("ovf_error", error, 1);
        chk("ovf_mem_sel", ifc.mem_sel, 1);
        chk("ovf_done", done, 0);
        chk("ovf_busy", busy, 0);
        chk("ovf_prog_len", prog_len, 64);
        chk("ovf_s_ready", ifc.s_ready, 0);
        chk("ovf_wr_cnt", wr_cnt, 329);
        chk("ovf_drain", exp_q.size(), 0);

        // Timeout: PC never reaches 0x01A.
        pc_value = 12'h011;
        pulse_start();
        chk("restart_err_clr", error, 0);
        load_front(1'b0, 256);
        load_prog(16'h0000);
        tick();
        chk("tmo_mem_sel_rel", ifc.mem_sel, 0);
        k = 0;
        while (error !== 2'd2 && k < 200) begin
            tick();
            k++;
        end
        chk("tmo_cycles", k, 50);
        chk("tmo_error", error, 2);
        chk("tmo_mem_sel", ifc.mem_sel, 1);
        chk("tmo_done", done, 0);
        chk("tmo_drain", exp_q.size(), 0);

`ifdef CNN_LOADER_CKSUM_EN
        // Bad checksum: CPU must never be released and the checksum word is not written.
        pulse_start();
        load_front(1'b0, 256);
        load_prog(16'h0001);
        tick();
        tick();
        chk("ck_error", error, 3);
        chk("ck_mem_sel", ifc.mem_sel, 1);
        chk("ck_done", done, 0);
        chk("ck_drain", exp_q.size(), 0);
`endif

        // Reset one cycle after image word 100, then a restarted load writes at 0x000.
        pulse_start();
        load_front(1'b0, 101);
        ifc.s_valid = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("mid_rst_mem_sel", ifc.mem_sel, 1);
        chk("mid_rst_mem_we", ifc.mem_we, 0);
        chk("mid_rst_mem_adr", ifc.mem_adr, 0);
        chk("mid_rst_mem_data", ifc.mem_data, 0);
        chk("mid_rst_s_ready", ifc.s_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_error", error, 0);
        chk("mid_rst_drain", exp_q.size(), 0);
        pulse_start();
        send_w(16'hBEEF, 1'b1, 12'h000);
        ifc.s_valid = 1'b0;
        tick();
        tick();
        chk("reload_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cnn_mem_loader.md
Name: cnn_mem_loader

Overview:
- Host-side boot sequencer for the CNN_16 CPU, replacing ad-hoc bench loading with synthesizable RTL.
- Accepts a valid/ready word stream and writes three memory regions in order: kernel (K_DIM×K_DIM words), image (IMG_W×IMG_H words), then program (terminated by an end word).
- Then hands memory to the CPU and watches its PC until the CPU reaches the program's end word.
- Sits between the host/DMA stream and the CPU's external memory port (sel/we/adr/data).

Parameters:
- DATA_W, 16, stream and memory word width
- ADDR_W, 12, memory address width
- K_DIM, 3, kernel side length; kernel region = K_DIM*K_DIM words
- IMG_W, 16, image width in words
- IMG_H, 16, image height in words
- KERN_BASE, 12'h000, first kernel address
- PROG_BASE, 12'h010, first program address
- IMG_BASE, 12'h100, first image address
- PROG_MAX, 64, maximum program words, end word included
- TIMEOUT_CYC, 100000, RUN-state cycle limit

Ports:
- clkn  in  1  clock, rising edge
- rstn  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse that begins a load; ignored unless in IDLE or DONE/ERR
- s_valid  in  1  stream word valid
- s_data  in  DATA_W  stream word
- s_ready  out  1  loader accepts word; transfer occurs when s_valid&&s_ready
- pc_value  in  ADDR_W  CPU program counter
- mem_sel  out  1  1 = host owns memory, 0 = CPU owns memory
- mem_we  out  1  memory write strobe
- mem_adr  out  ADDR_W  write address
- mem_data  out  DATA_W  write data
- busy  out  1  high in every state except IDLE/DONE/ERR
- done  out  1  CPU reached program end
- error  out  2  0 none, 1 program overflow, 2 timeout, 3 checksum mismatch
- prog_len  out  clog2(PROG_MAX+1)  program words written, end word included

Behaviour:
- Reset: all outputs registered.
  - mem_sel=1; mem_we=0; mem_adr=0; mem_data=0; s_ready=0; busy=0; done=0; error=0; prog_len=0; state IDLE.
  - Reset mid-operation aborts immediately, with the same values the next cycle; partial memory contents are left as written.
- States: IDLE, LD_KERN, LD_IMG, LD_PROG, [LD_CKSUM], RELEASE, RUN, DONE, ERR.
- start in IDLE/DONE/ERR:
  - Clears done, error and prog_len.
  - Next state is LD_KERN; mem_sel=1.
- s_ready=1 only in the LD_* states.
- Write latency: a word accepted at edge n drives mem_we=1, mem_adr and mem_data during cycle n+1. mem_we=0 in any cycle with no accepted word.
  - Gaps in s_valid produce gaps in mem_we; the address does not advance.
- LD_KERN: word i goes to KERN_BASE+i. After K_DIM*K_DIM words, go to LD_IMG.
- LD_IMG: word r*IMG_W+c goes to IMG_BASE+r*IMG_W+c. After IMG_W*IMG_H words, go to LD_PROG. A single flat counter is used; address arithmetic is modulo 2^ADDR_W.
- LD_PROG:
  - Word j goes to PROG_BASE+j, and prog_len increments per word.
  - Accepting PROG_END_WORD (16'hFFFF) writes it, latches end_adr=PROG_BASE+j, and goes to RELEASE (or LD_CKSUM when enabled).
  - If PROG_MAX words are accepted with no end word, the last word is still written, then error=1 and the state goes to ERR.
- RELEASE: exactly one cycle with mem_sel=0, mem_we=0, s_ready=0; then RUN.
- RUN:
  - mem_sel=0; the timeout counter starts at 0 on entry.
  - pc_value==end_adr → DONE.
  - Counter reaches TIMEOUT_CYC-1 with no match → error=2, ERR.
  - If both occur in the same cycle, the PC match wins.
- DONE: done=1 and busy=0; mem_sel stays 0 until the next start or reset.
- ERR: mem_sel=1; error is held until start or reset.
- start while busy=1 has no effect.

Optional Feature:
- CNN_LOADER_CKSUM_EN defined:
  - After the end word, state LD_CKSUM accepts one more stream word.
  - That word is compared with the 16-bit wraparound sum of every word accepted in LD_KERN/LD_IMG/LD_PROG. The checksum word itself is not written.
  - Match → RELEASE. Mismatch → error=3, ERR, and the CPU is never released.
- CNN_LOADER_CKSUM_EN undefined: no LD_CKSUM state, no accumulator; the end word goes directly to RELEASE.

Decomposition:
- Package cnn_loader_pkg holds:
  - state enum
  - error code constants (ERR_NONE, ERR_PROG_OVF, ERR_TIMEOUT, ERR_CKSUM)
  - PROG_END_WORD = 16'hFFFF
- No sub-module: a single FSM plus one shared word counter and a timeout counter. The checksum accumulator stays inline under the macro.

Test Plan:
- Default parameters:
  - Stimulus: 9 kernel words, 256 image words, then the program 0300..0308, 3000, FFFF with s_valid held high.
  - Response: writes at 0x000-0x008, 0x100-0x1FF and 0x010-0x01A, giving 276 mem_we pulses; prog_len=11; one RELEASE cycle.
  - Then: drive pc_value=0x01A → done=1 next cycle.
- Backpressure: s_valid toggled 1,0,0,1 during LD_IMG → exactly one write per accepted word, addresses contiguous, no duplicates.
- Overflow: 64 program words with no FFFF → 64 writes at 0x010-0x04F, then error=1, mem_sel=1, done=0.
- Timeout: with TIMEOUT_CYC=50 and pc_value held at 0x011 → error=2 exactly 50 cycles after RUN entry, mem_sel returns to 1.
- Reset mid-load: rstn=0 for one cycle after image word 100 → the next cycle shows all reset values. A restarted load then begins writing at 0x000.
- CNN_LOADER_CKSUM_EN:
  - Correct sum word → RELEASE.
  - Sum+1 → error=3, mem_sel stays 1, and the checksum word is not written.
